// File: rtl/qaccum.sv
// Sign-magnitude Q-format accumulator: sums LEN product terms from an upstream
// fixed-point multiplier and returns a saturated sign-magnitude result.
module qaccum #(
  parameter int Q   = 15,
  parameter int N   = 32,
  parameter int LEN = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_valid,
  input  logic [N-1:0] i_product,
  input  logic         i_ovr,
  output logic         o_ready,
  output logic         o_valid,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  input  logic         i_ready
);

  localparam int       AW       = N + 4;
  localparam logic [4:0] LAST_CNT = 5'(LEN - 1);
  // An out-of-range configuration never accepts terms rather than misbehaving.
  localparam logic     CFG_OK   = 1'((Q < N - 1) && (LEN >= 2) && (LEN <= 16));

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t                state_q;
  logic signed [AW-1:0]  acc_q;
  logic [4:0]            cnt_q;
  logic                  sticky_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [N-1:0]          result_q;
  logic                  ovr_q;

  logic signed [AW-1:0]  mag_s;
  logic signed [AW-1:0]  term_s;
  logic signed [AW-1:0]  sum_d;
  logic [AW-1:0]         abs_s;
  logic                  neg_s;
  logic                  sat_s;
  logic [N-1:0]          result_d;
  logic                  ovr_d;
  logic                  accept_s;

  assign accept_s = i_valid && ready_q;
  assign mag_s    = {{5{1'b0}}, i_product[N-2:0]};
  assign term_s   = i_product[N-1] ? -mag_s : mag_s;
  assign sum_d    = acc_q + term_s;
  assign neg_s    = sum_d[AW-1];
  assign abs_s    = neg_s ? -sum_d : sum_d;
  assign sat_s    = |abs_s[AW-1:N-1];
  // A negative sum always has a nonzero magnitude, so negative zero cannot appear.
  assign result_d = sat_s ? {neg_s, {(N-1){1'b1}}} : {neg_s, abs_s[N-2:0]};
  assign ovr_d    = sticky_q | i_ovr | sat_s;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= 5'd0;
      sticky_q <= 1'b0;
      ready_q  <= CFG_OK;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovr_q    <= 1'b0;
    end else if (i_clear) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      cnt_q    <= 5'd0;
      sticky_q <= 1'b0;
      ready_q  <= CFG_OK;
      valid_q  <= 1'b0;
      result_q <= '0;
      ovr_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept_s) begin
            if (cnt_q == LAST_CNT) begin
              state_q  <= S_DONE;
              ready_q  <= 1'b0;
              valid_q  <= 1'b1;
              result_q <= result_d;
              ovr_q    <= ovr_d;
              acc_q    <= sum_d;
              sticky_q <= sticky_q | i_ovr;
            end else begin
              state_q  <= S_ACCUM;
              acc_q    <= sum_d;
              cnt_q    <= cnt_q + 5'd1;
              sticky_q <= sticky_q | i_ovr;
            end
          end
        end
        S_DONE: begin
          if (i_ready) begin
            state_q  <= S_IDLE;
            ready_q  <= CFG_OK;
            valid_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= 5'd0;
            sticky_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ready_q  <= CFG_OK;
          valid_q  <= 1'b0;
          acc_q    <= '0;
          cnt_q    <= 5'd0;
          sticky_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_ovr    = ovr_q;

endmodule

// File: tb/tb_qaccum.sv
// Scoreboard bench for qaccum (N=32, Q=15, LEN=4): stimulus pushes expected
// {ovr, result}; a negedge monitor pops on every output handshake.
module tb_qaccum;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [31:0] product;
  logic        in_ovr;
  logic        ready;
  logic        out_valid;
  logic [31:0] result;
  logic        out_ovr;
  logic        out_ready;

  logic [32:0] sb[$];
  int          n_pass;
  int          n_total;

  qaccum #(.Q(15), .N(32), .LEN(4)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_clear  (clear),
    .i_valid  (in_valid),
    .i_product(product),
    .i_ovr    (in_ovr),
    .o_ready  (out_ready),
    .o_valid  (out_valid),
    .o_result (result),
    .o_ovr    (out_ovr),
    .i_ready  (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
  endtask

  // Output monitor: every handshake must match the oldest expected result.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst && out_valid && ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got %08h ovr %0b expected none at %0t", result, out_ovr, $time);
      end else begin
        e = sb.pop_front();
        chk("result", result, e[31:0]);
        chk("ovr", {31'd0, out_ovr}, {31'd0, e[32]});
      end
    end
  end

  task automatic term(input logic [31:0] p, input logic ov);
    in_valid = 1'b1;
    product  = p;
    in_ovr   = ov;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    product  = 32'hDEAD_BEEF;
    in_ovr   = 1'b1;
  endtask

  task automatic run4(input logic [127:0] ps, input logic [3:0] ovs,
                      input logic [31:0] er, input logic eo, input logic gaps);
    sb.push_back({eo, er});
    for (int k = 0; k < 4; k++) begin
      term(ps[127 - 32*k -: 32], ovs[3 - k]);
      if (gaps) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    product = 32'd0;
    in_ovr = 1'b0;
    ready = 1'b1;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_ovr", {31'd0, out_ovr}, 32'd0);
    chk("rst_ready", {31'd0, out_ready}, 32'd1);
    #20;
    rst = 1'b0;
    @(posedge clk);
    #1;

    run4({32'h00008000, 32'h00008000, 32'h00008000, 32'h80004000}, 4'b0000, 32'h00014000, 1'b0, 1'b0);
    run4({32'h80008000, 32'h80008000, 32'h80008000, 32'h80008000}, 4'b0000, 32'h80020000, 1'b0, 1'b0);
    run4({32'h00008000, 32'h80008000, 32'h80000000, 32'h00000000}, 4'b0000, 32'h00000000, 1'b0, 1'b0);
    run4({32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, 4'b0000, 32'h7FFFFFFF, 1'b1, 1'b0);
    run4({32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0000, 32'hFFFFFFFF, 1'b1, 1'b0);
    run4({32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000}, 4'b0100, 32'h00020000, 1'b1, 1'b0);
    run4({32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000}, 4'b0000, 32'h00020000, 1'b0, 1'b0);
    // Saturation boundary, with idle gaps carrying garbage and i_ovr=1.
    run4({32'h7FFFFFFF, 32'h00000000, 32'h00000000, 32'h00000000}, 4'b0000, 32'h7FFFFFFF, 1'b0, 1'b1);
    run4({32'h7FFFFFFF, 32'h00000001, 32'h00000000, 32'h00000000}, 4'b0000, 32'h7FFFFFFF, 1'b1, 1'b1);
    run4({32'hFFFFFFFF, 32'h80000001, 32'h00000000, 32'h00000000}, 4'b0000, 32'hFFFFFFFF, 1'b1, 1'b0);

    // Held result under back-pressure with i_valid asserted throughout.
    ready = 1'b0;
    sb.push_back({1'b0, 32'h00010000});
    for (int k = 0; k < 4; k++) term(32'h00004000, 1'b0);
    in_valid = 1'b1;
    product  = 32'h00010000;
    in_ovr   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_result", result, 32'h00010000);
      chk("hold_ready", {31'd0, out_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_ovr   = 1'b0;
    chk("post_hs_ready", {31'd0, out_ready}, 32'd1);
    chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("post_hs_result_kept", result, 32'h00010000);
    run4({32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000}, 4'b0000, 32'h00020000, 1'b0, 1'b0);

    // Reset pulse between edges after two terms (with overflow flags set).
    term(32'h00008000, 1'b1);
    term(32'h00008000, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_result", result, 32'd0);
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_ready", {31'd0, out_ready}, 32'd1);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Clear with a simultaneous term after three terms.
    for (int k = 0; k < 3; k++) term(32'h00008000, 1'b1);
    clear    = 1'b1;
    in_valid = 1'b1;
    product  = 32'h00008000;
    in_ovr   = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    in_ovr   = 1'b0;
    chk("clear_valid", {31'd0, out_valid}, 32'd0);
    chk("clear_ready", {31'd0, out_ready}, 32'd1);
    run4({32'h00008000, 32'h00008000, 32'h00008000, 32'h00008000}, 4'b0000, 32'h00020000, 1'b0, 1'b0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/qaccum.md
QACCUM -- requirements
Module: qaccum

Interface
REQ-001 The block SHALL have parameter Q, default 15, meaning the number of fractional bits of every operand and of the result.
REQ-002 The block SHALL have parameter N, default 32, meaning the word width: bit N-1 is the sign and bits N-2:0 are the magnitude (sign-magnitude format).
REQ-003 The block SHALL have parameter LEN, default 4, legal range 2..16, meaning the number of terms accumulated per result.
REQ-004 The block SHALL have port i_clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_rst, input, 1 bit, reset; asynchronous, active-high.
REQ-006 The block SHALL have port i_clear, input, 1 bit, synchronous abort of the current accumulation.
REQ-007 The block SHALL have port i_valid, input, 1 bit, meaning the upstream product term is valid.
REQ-008 The block SHALL have port i_product, input, N bits, the sign-magnitude Q-format product term from the upstream fixed-point multiplier.
REQ-009 The block SHALL have port i_ovr, input, 1 bit, the upstream overflow flag, qualified by i_valid.
REQ-010 The block SHALL have port o_ready, output, 1 bit, meaning the block can accept a term this cycle.
REQ-011 The block SHALL have port o_valid, output, 1 bit, meaning o_result and o_ovr are valid.
REQ-012 The block SHALL have port o_result, output, N bits, the sign-magnitude Q-format sum of LEN terms.
REQ-013 The block SHALL have port o_ovr, output, 1 bit, meaning the result saturated or an accepted term carried i_ovr.
REQ-014 The block SHALL have port i_ready, input, 1 bit, meaning downstream consumes the result this cycle.

Function
REQ-015 The block SHALL implement states IDLE (count=0), ACCUM (1..LEN-1 terms taken) and DONE (result held).
REQ-016 o_ready SHALL be 1 in IDLE and ACCUM and 0 in DONE.
REQ-017 A term SHALL be accepted only on a cycle with i_valid=1 and o_ready=1; otherwise i_product and i_ovr are ignored.
REQ-018 Each accepted term SHALL be converted to two's complement: magnitude i_product[N-2:0], negated when i_product[N-1]=1; 0x80000000 (negative zero) equals zero.
REQ-019 The internal accumulator SHALL be signed, N+4 bits wide, and SHALL not wrap for any LEN up to 16.
REQ-020 The block SHALL keep one sticky overflow bit, set when any accepted term has i_ovr=1 and cleared at the start of each new result.
REQ-021 Accepting the first term SHALL move IDLE to ACCUM; accepting the LEN-th term SHALL move ACCUM to DONE.
REQ-022 o_result, o_ovr and o_valid=1 SHALL be registered on the edge that accepts the LEN-th term, so o_valid is high in the next cycle (latency 1 cycle after the last term).
REQ-023 o_result SHALL be the final sum converted back to sign-magnitude; a zero sum SHALL give 0x00000000, never negative zero.
REQ-024 A sum with magnitude above 2^(N-1)-1 SHALL saturate to magnitude all-ones with the correct sign and SHALL set o_ovr=1.
REQ-025 In DONE, o_result, o_ovr and o_valid SHALL hold until a cycle with i_ready=1, after which the next state SHALL be IDLE with o_valid=0 and the accumulator, count and sticky bit cleared.
REQ-026 i_clear=1 SHALL force IDLE, clear the accumulator, count, sticky bit and o_valid, and SHALL discard any term presented in the same cycle; i_clear has priority over i_valid and i_ready.
REQ-027 o_result and o_ovr SHALL retain their last value while o_valid=0 after a handshake, and SHALL be zeroed only by reset or i_clear.

Reset
REQ-028 While i_rst=1 the block SHALL immediately, without waiting for a clock edge, force IDLE, clear accumulator, count and sticky bit, and drive o_valid=0, o_result=0, o_ovr=0 and o_ready=1.
REQ-029 Reset asserted during ACCUM or DONE SHALL discard partial and held results; the first term after reset release starts a new sum.

Verification (N=32, Q=15, LEN=4; 1.0 = 0x00008000)
REQ-030 Terms 0x00008000 x3 then 0x80004000 on consecutive cycles, i_ready=1 -> o_valid for one cycle after the fourth term, o_result=0x00014000, o_ovr=0.
REQ-031 Terms 0x80008000 x4 -> o_result=0x80020000, o_ovr=0; terms +1.0, -1.0, 0x80000000, 0 -> o_result=0x00000000.
REQ-032 Terms 0x7FFFFFFF x4 -> o_result=0x7FFFFFFF, o_ovr=1; terms 0xFFFFFFFF x4 -> o_result=0xFFFFFFFF, o_ovr=1.
REQ-033 Terms 1.0 x4 with i_ovr=1 on the second only -> o_result=0x00020000, o_ovr=1; the next result with i_ovr=0 -> o_ovr=0.
REQ-034 Result ready while i_ready=0 for 5 cycles with i_valid=1 throughout -> o_valid and o_result stable and o_ready=0; on the i_ready=1 cycle the term is not accepted; the next cycle is IDLE with o_ready=1.
REQ-035 Reset pulse between clock edges after 2 terms -> outputs zero at once; i_clear with i_valid after 3 terms -> that term is dropped; then 4 fresh 1.0 terms -> o_result=0x00020000.
